// File: rtl/spi_mem_xfer_engine.sv
// -----------------------------------------------------------------------------
// spi_mem_xfer_engine
//
// Bit-level SPI master (mode 0) that turns one memory-controller request into a
// single 64-bit serial SRAM frame: 8-bit command, 24-bit byte address and
// 32-bit data, all shifted MSB first. Read data is collected from the last 32
// MISO samples and returned on RD together with a one-cycle done pulse.
//
// Frame timeline (cycle 0 = the cycle in which start is sampled in IDLE,
// D = CLK_DIV):
//   cycles 1 .. 128*D        SHIFT : 64 bits, each D cycles low then D high
//   cycles 128*D+1 .. 129*D  HOLD  : spi_clk low, CS still asserted
//   cycle  129*D+1           done  : CS released, RD loaded (reads only)
//   CS_IDLE_CYCLES cycles    GAP   : CS high, busy still high
//
// Ports:
//   CLK       system clock, everything on posedge
//   reset     synchronous active-high reset, aborts any frame
//   start     request strobe, only looked at while idle
//   we        1 = write, 0 = read (captured with start)
//   A         byte address, low ADDR_BITS bits used (captured with start)
//   WD        write data (captured with start)
//   RD        read data, held until the next read completes
//   done      one-cycle pulse at the end of a frame
//   busy      high from the cycle after acceptance to the end of the gap
//   spi_clk   serial clock, idles low
//   spi_mosi  serial data out
//   spi_miso  serial data in
//   spi_cs_n  chip select, active low
// -----------------------------------------------------------------------------
module spi_mem_xfer_engine #(
    parameter int          CLK_DIV        = 2,
    parameter int          ADDR_BITS      = 24,
    parameter logic [7:0]  CMD_READ       = 8'h03,
    parameter logic [7:0]  CMD_WRITE      = 8'h02,
    parameter int          CS_IDLE_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    input  logic        we,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        done,
    output logic        busy,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n
);

    localparam int PH_W  = $clog2(CLK_DIV) + 1;
    localparam int GAP_W = $clog2(CS_IDLE_CYCLES) + 1;

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_IDLE_CYCLES - 1);

    // The address field in the frame is always 24 bits wide; a narrower
    // ADDR_BITS is zero-extended into it.
    localparam int ADDR_USED = (ADDR_BITS < 24) ? ADDR_BITS : 24;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t            r_state;
    logic [63:0]       r_shift;     // bit currently on MOSI sits in [63]
    logic [31:0]       r_rx;
    logic              r_we;
    logic [5:0]        r_bit;
    logic [PH_W-1:0]   r_phase;
    logic [GAP_W-1:0]  r_gap;
    logic              r_sclk;
    logic              r_mosi;
    logic              r_cs_n;
    logic              r_done;
    logic              r_busy;
    logic [31:0]       r_rd;

    logic [23:0]       w_addr;
    logic [63:0]       w_frame;
    logic              w_unused_addr;

    assign w_addr        = 24'(A[ADDR_USED-1:0]);
    assign w_unused_addr = ^A[31:ADDR_USED];

    // Reads send zeros in the data phase; the memory drives MISO then.
    assign w_frame = {(we ? CMD_WRITE : CMD_READ), w_addr, (we ? WD : 32'h0)};

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_rx     <= '0;
            r_we     <= 1'b0;
            r_bit    <= '0;
            r_phase  <= '0;
            r_gap    <= '0;
            r_sclk   <= 1'b0;
            r_mosi   <= 1'b0;
            r_cs_n   <= 1'b1;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_rd     <= '0;
        end else begin
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_SHIFT;
                        r_shift <= w_frame;
                        r_we    <= we;
                        r_mosi  <= w_frame[63];
                        r_cs_n  <= 1'b0;
                        r_sclk  <= 1'b0;
                        r_bit   <= '0;
                        r_phase <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (r_phase != PH_LAST) begin
                        r_phase <= r_phase + PH_W'(1);
                    end else begin
                        r_phase <= '0;
                        if (!r_sclk) begin
                            // Rising edge: the slave's bit is sampled on the
                            // same posedge that raises spi_clk. Only bits
                            // 32..63 (data phase) are kept, and only for reads.
                            r_sclk <= 1'b1;
                            if (!r_we && r_bit[5]) begin
                                r_rx <= {r_rx[30:0], spi_miso};
                            end
                        end else begin
                            // Falling edge: start of the next low phase, the
                            // only point where MOSI is allowed to change.
                            r_sclk <= 1'b0;
                            if (r_bit == 6'd63) begin
                                r_state <= S_HOLD;
                                r_mosi  <= 1'b0;
                            end else begin
                                r_bit   <= r_bit + 6'd1;
                                r_shift <= {r_shift[62:0], 1'b0};
                                r_mosi  <= r_shift[62];
                            end
                        end
                    end
                end

                S_HOLD: begin
                    if (r_phase != PH_LAST) begin
                        r_phase <= r_phase + PH_W'(1);
                    end else begin
                        r_phase <= '0;
                        r_state <= S_GAP;
                        r_cs_n  <= 1'b1;
                        r_done  <= 1'b1;
                        r_gap   <= '0;
                        if (!r_we) begin
                            r_rd <= r_rx;
                        end
                    end
                end

                S_GAP: begin
                    // The done cycle is the first gap cycle.
                    if (r_gap == GAP_LAST) begin
                        r_gap   <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cs_n  <= 1'b1;
                    r_sclk  <= 1'b0;
                    r_mosi  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign RD       = r_rd;
    assign done     = r_done;
    assign busy     = r_busy;
    assign spi_clk  = r_sclk;
    assign spi_mosi = r_mosi;
    assign spi_cs_n = r_cs_n;

endmodule

// File: tb/tb_spi_mem_xfer_engine.sv
// -----------------------------------------------------------------------------
// Testbench for spi_mem_xfer_engine. Two instances share the clock and reset:
// index 0 is built with CLK_DIV=2, index 1 with CLK_DIV=1. A negedge monitor
// acts as the SPI memory: it records MOSI on every rising spi_clk, logs the
// spi_clk level for every CS-low cycle, and feeds MISO with the selected data
// word during the data phase (random bits elsewhere).
// -----------------------------------------------------------------------------
module tb_spi_mem_xfer_engine;

    localparam int D0 = 2;
    localparam int D1 = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  start_v = 2'b00;
    logic        we = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] WD = '0;
    logic [31:0] rd0, rd1;
    logic [1:0]  done_v, busy_v, sclk_v, mosi_v, cs_n_v, miso_v;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Memory-side model state (written only by the monitor)
    logic [63:0] mosi_sh[2];
    logic [63:0] last_frame[2];
    int          edge_cnt[2];
    int          last_edges[2];
    int          frames_started[2];
    int          done_cnt[2];
    int          stray_edges[2];
    int          trace_len[2];
    logic        trace_v[2][0:299];
    logic        prev_clk[2];
    logic        prev_cs[2];

    // Written only by the stimulus tasks
    logic [31:0] miso_data[2];
    logic [31:0] model_rd[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_mem_xfer_engine #(.CLK_DIV(D0)) dut0 (
        .CLK(clk), .reset(reset), .start(start_v[0]), .we(we), .A(A), .WD(WD),
        .RD(rd0), .done(done_v[0]), .busy(busy_v[0]), .spi_clk(sclk_v[0]),
        .spi_mosi(mosi_v[0]), .spi_miso(miso_v[0]), .spi_cs_n(cs_n_v[0])
    );

    spi_mem_xfer_engine #(.CLK_DIV(D1)) dut1 (
        .CLK(clk), .reset(reset), .start(start_v[1]), .we(we), .A(A), .WD(WD),
        .RD(rd1), .done(done_v[1]), .busy(busy_v[1]), .spi_clk(sclk_v[1]),
        .spi_mosi(mosi_v[1]), .spi_miso(miso_v[1]), .spi_cs_n(cs_n_v[1])
    );

    function automatic logic [31:0] get_rd(input int d);
        return (d == 0) ? rd0 : rd1;
    endfunction

    function automatic logic [63:0] exp_frame(input logic w, input logic [31:0] a,
                                              input logic [31:0] wd);
        return {(w ? 8'h02 : 8'h03), a[23:0], (w ? wd : 32'h0)};
    endfunction

    // Rising edges seen once the current negedge has been accounted for.
    function automatic int edges_after(input int d);
        if (cs_n_v[d] !== 1'b0) return 64;
        if (prev_cs[d] !== 1'b0) return 0;
        return edge_cnt[d] + ((sclk_v[d] === 1'b1 && prev_clk[d] === 1'b0) ? 1 : 0);
    endfunction

    function automatic logic miso_for(input int d);
        int n;
        n = edges_after(d);
        if (n >= 32 && n < 64) return miso_data[d][63 - n];
        return 1'($urandom);
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            prev_clk[d] <= sclk_v[d];
            prev_cs[d]  <= cs_n_v[d];
            miso_v[d]   <= miso_for(d);
            if (done_v[d] === 1'b1) done_cnt[d] <= done_cnt[d] + 1;
            if (cs_n_v[d] === 1'b0) begin
                if (prev_cs[d] !== 1'b0) begin
                    frames_started[d] <= frames_started[d] + 1;
                    edge_cnt[d]       <= 0;
                    mosi_sh[d]        <= '0;
                    trace_v[d][0]     <= sclk_v[d];
                    trace_len[d]      <= 1;
                end else begin
                    if (trace_len[d] < 300) trace_v[d][trace_len[d]] <= sclk_v[d];
                    trace_len[d] <= trace_len[d] + 1;
                    if (sclk_v[d] === 1'b1 && prev_clk[d] === 1'b0) begin
                        mosi_sh[d]  <= {mosi_sh[d][62:0], mosi_v[d]};
                        edge_cnt[d] <= edge_cnt[d] + 1;
                    end
                end
            end else begin
                if (prev_cs[d] === 1'b0) begin
                    last_frame[d] <= mosi_sh[d];
                    last_edges[d] <= edge_cnt[d];
                end
                if (sclk_v[d] === 1'b1 && prev_clk[d] === 1'b0)
                    stray_edges[d] <= stray_edges[d] + 1;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Drives one request and waits (bounded) for done; returns the done cycle
    // relative to the start cycle, or -1 on timeout. Ends in the done cycle.
    task automatic xfer(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] md, output int done_rel);
        int s;
        int n;
        miso_data[d] = md;
        we = w; A = a; WD = wd;
        start_v[d] = 1'b1;
        s = cyc;
        step();
        start_v[d] = 1'b0;
        n = 0;
        while (done_v[d] !== 1'b1 && n < 600) begin
            step();
            n++;
        end
        done_rel = (done_v[d] === 1'b1) ? (cyc - s) : -1;
    endtask

    task automatic test_reset();
        int base;
        reset = 1'b1; start_v = 2'b11; we = 1'b1; A = $urandom; WD = $urandom;
        for (int i = 0; i < 3; i++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({cs_n_v[d], sclk_v[d], mosi_v[d], done_v[d], busy_v[d]} !== 5'b10000 ||
                    get_rd(d) !== 32'h0) begin
                    failures++;
                    $display("FAIL reset_outputs dut%0d cyc%0d: cs,clk,mosi,done,busy=%b%b%b%b%b RD=%h expected 10000 RD=0",
                             d, i, cs_n_v[d], sclk_v[d], mosi_v[d], done_v[d], busy_v[d], get_rd(d));
                end
            end
        end
        base = frames_started[0] + frames_started[1];
        reset = 1'b0; start_v = 2'b00;
        model_rd[0] = '0; model_rd[1] = '0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (frames_started[0] + frames_started[1] != base || cs_n_v !== 2'b11 || busy_v !== 2'b00) begin
            failures++;
            $display("FAIL reset_no_start: frames=%0d cs_n=%b busy=%b expected frames=%0d cs_n=11 busy=00",
                     frames_started[0] + frames_started[1], cs_n_v, busy_v, base);
        end
    endtask

    task automatic test_write();
        int rel, dbase, errs;
        dbase = done_cnt[0];
        xfer(0, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, $urandom, rel);
        checks++;
        if (rel != 1 + 129 * D0) begin
            failures++; $display("FAIL write_done_cycle: got %0d expected %0d", rel, 1 + 129 * D0);
        end
        checks++;
        if (last_edges[0] != 64 || last_frame[0] !== 64'h02_000104_DEADBEEF) begin
            failures++;
            $display("FAIL write_mosi: edges=%0d frame=%h expected edges=64 frame=02000104deadbeef",
                     last_edges[0], last_frame[0]);
        end
        checks++;
        if (rd0 !== model_rd[0]) begin
            failures++; $display("FAIL write_rd_unchanged: got %h expected %h", rd0, model_rd[0]);
        end
        errs = 0;
        for (int i = 0; i < 129 * D0; i++)
            if (trace_v[0][i] !== ((i < 128 * D0) ? 1'((i / D0) % 2) : 1'b0)) errs++;
        checks++;
        if (errs != 0 || trace_len[0] != 129 * D0) begin
            failures++;
            $display("FAIL write_sclk_pattern: errors=%0d cs_low_cycles=%0d expected 0 and %0d",
                     errs, trace_len[0], 129 * D0);
        end
        step(); step();
        checks++;
        if (done_cnt[0] - dbase != 1 || busy_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL write_single_done: done pulses=%0d busy=%b expected 1 and 0",
                     done_cnt[0] - dbase, busy_v[0]);
        end
    endtask

    task automatic test_read();
        int rel;
        xfer(0, 1'b0, 32'h0000_0200, $urandom, 32'hA5A5_0F0F, rel);
        model_rd[0] = 32'hA5A5_0F0F;
        checks++;
        if (rel != 1 + 129 * D0 || rd0 !== 32'hA5A5_0F0F) begin
            failures++;
            $display("FAIL read_done: cycle=%0d RD=%h expected %0d and a5a50f0f", rel, rd0, 1 + 129 * D0);
        end
        checks++;
        if (last_frame[0] !== 64'h03_000200_00000000) begin
            failures++; $display("FAIL read_mosi: got %h expected 0300020000000000", last_frame[0]);
        end
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (rd0 !== 32'hA5A5_0F0F) begin
            failures++; $display("FAIL read_rd_held: got %h expected a5a50f0f", rd0);
        end
    endtask

    task automatic test_busy_reject();
        logic        w1, w2;
        logic [31:0] a1, wd1, md1, a2, wd2, md2;
        int s, base, rel, n;
        logic got;
        w1 = 1'($urandom); a1 = $urandom; wd1 = $urandom; md1 = $urandom;
        base = frames_started[0];
        miso_data[0] = md1; we = w1; A = a1; WD = wd1;
        start_v[0] = 1'b1;
        s = cyc;
        step();
        start_v[0] = 1'b0;
        got = 1'b0; n = 0;
        while (!got && n < 600) begin
            if (cyc - s == 50) begin
                start_v[0] = 1'b1; we = ~w1; A = $urandom; WD = $urandom;
            end
            step();
            start_v[0] = 1'b0;
            n++;
            if (done_v[0] === 1'b1) got = 1'b1;
        end
        rel = got ? (cyc - s) : -1;
        if (!w1) model_rd[0] = md1;
        checks++;
        if (rel != 1 + 129 * D0 || last_frame[0] !== exp_frame(w1, a1, wd1) || rd0 !== model_rd[0]) begin
            failures++;
            $display("FAIL busy_first_frame: cycle=%0d frame=%h RD=%h expected %0d %h %h",
                     rel, last_frame[0], rd0, 1 + 129 * D0, exp_frame(w1, a1, wd1), model_rd[0]);
        end
        // start while in the first gap cycle must be dropped
        start_v[0] = 1'b1; A = $urandom;
        step();
        start_v[0] = 1'b0;
        checks++;
        if (busy_v[0] !== 1'b1 || cs_n_v[0] !== 1'b1) begin
            failures++;
            $display("FAIL busy_gap: busy=%b cs_n=%b expected 1 1", busy_v[0], cs_n_v[0]);
        end
        step();
        checks++;
        if (busy_v[0] !== 1'b0 || frames_started[0] - base != 1) begin
            failures++;
            $display("FAIL busy_rejects: busy=%b frames=%0d expected 0 and 1",
                     busy_v[0], frames_started[0] - base);
        end
        // first idle cycle (cycle 261): accepted
        w2 = 1'($urandom); a2 = $urandom; wd2 = $urandom; md2 = $urandom;
        xfer(0, w2, a2, wd2, md2, rel);
        if (!w2) model_rd[0] = md2;
        checks++;
        if (rel != 1 + 129 * D0 || last_frame[0] !== exp_frame(w2, a2, wd2) ||
            rd0 !== model_rd[0] || frames_started[0] - base != 2) begin
            failures++;
            $display("FAIL busy_accept_idle: cycle=%0d frame=%h RD=%h frames=%0d expected %0d %h %h 2",
                     rel, last_frame[0], rd0, frames_started[0] - base,
                     1 + 129 * D0, exp_frame(w2, a2, wd2), model_rd[0]);
        end
        step(); step();
    endtask

    task automatic test_abort();
        int rel, s, n, dbase;
        logic [31:0] a, md;
        md = $urandom | 32'h1;
        xfer(0, 1'b0, $urandom, $urandom, md, rel);
        model_rd[0] = md;
        step(); step();
        dbase = done_cnt[0];
        a = $urandom;
        miso_data[0] = $urandom; we = 1'b0; A = a;
        start_v[0] = 1'b1;
        s = cyc;
        step();
        start_v[0] = 1'b0;
        n = 0;
        while (cyc - s < 1 + 2 * 20 * D0 + D0 && n < 200) begin
            step();
            n++;
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_rd[0] = '0; model_rd[1] = '0;
        checks++;
        if (cs_n_v[0] !== 1'b1 || sclk_v[0] !== 1'b0 || busy_v[0] !== 1'b0 ||
            done_v[0] !== 1'b0 || rd0 !== 32'h0) begin
            failures++;
            $display("FAIL abort_outputs: cs_n=%b clk=%b busy=%b done=%b RD=%h expected 1 0 0 0 0",
                     cs_n_v[0], sclk_v[0], busy_v[0], done_v[0], rd0);
        end
        md = $urandom;
        a = $urandom;
        xfer(0, 1'b0, a, $urandom, md, rel);
        model_rd[0] = md;
        checks++;
        if (rel != 1 + 129 * D0 || rd0 !== md || last_frame[0] !== exp_frame(1'b0, a, 32'h0) ||
            done_cnt[0] - dbase != 1) begin
            failures++;
            $display("FAIL abort_then_read: cycle=%0d RD=%h frame=%h dones=%0d expected %0d %h %h 1",
                     rel, rd0, last_frame[0], done_cnt[0] - dbase, 1 + 129 * D0, md,
                     exp_frame(1'b0, a, 32'h0));
        end
        step(); step();
    endtask

    task automatic test_back_to_back();
        logic w;
        logic [31:0] a, wd, md;
        int rel;
        for (int t = 0; t < 6; t++) begin
            w = 1'($urandom); a = $urandom; wd = $urandom; md = $urandom;
            xfer(0, w, a, wd, md, rel);
            if (!w) model_rd[0] = md;
            checks++;
            if (rel != 1 + 129 * D0 || last_frame[0] !== exp_frame(w, a, wd) ||
                last_edges[0] != 64 || rd0 !== model_rd[0]) begin
                failures++;
                $display("FAIL b2b_%0d: cycle=%0d frame=%h edges=%0d RD=%h expected %0d %h 64 %h",
                         t, rel, last_frame[0], last_edges[0], rd0,
                         1 + 129 * D0, exp_frame(w, a, wd), model_rd[0]);
            end
            step(); step();
        end
    endtask

    task automatic test_clkdiv1();
        logic w;
        logic [31:0] a, wd, md;
        int rel, errs;
        for (int t = 0; t < 3; t++) begin
            w = (t == 0) ? 1'b0 : 1'($urandom);
            a = $urandom; wd = $urandom; md = $urandom;
            xfer(1, w, a, wd, md, rel);
            if (!w) model_rd[1] = md;
            errs = 0;
            for (int i = 0; i < 129 * D1; i++)
                if (trace_v[1][i] !== ((i < 128 * D1) ? 1'((i / D1) % 2) : 1'b0)) errs++;
            checks++;
            if (rel != 1 + 129 * D1 || last_frame[1] !== exp_frame(w, a, wd) ||
                rd1 !== model_rd[1] || errs != 0 || trace_len[1] != 129 * D1) begin
                failures++;
                $display("FAIL clkdiv1_%0d: cycle=%0d frame=%h RD=%h clk_errs=%0d cs_low=%0d expected %0d %h %h 0 %0d",
                         t, rel, last_frame[1], rd1, errs, trace_len[1],
                         1 + 129 * D1, exp_frame(w, a, wd), model_rd[1], 129 * D1);
            end
            step(); step();
        end
        checks++;
        if (stray_edges[0] != 0 || stray_edges[1] != 0) begin
            failures++;
            $display("FAIL stray_sclk: got %0d/%0d expected 0/0", stray_edges[0], stray_edges[1]);
        end
    endtask

    initial begin
        miso_data[0] = '0; miso_data[1] = '0;
        model_rd[0] = '0;  model_rd[1] = '0;
        test_reset();
        test_write();
        test_read();
        test_busy_reject();
        test_abort();
        test_back_to_back();
        test_clkdiv1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
